// File: rtl/buff_uart_arbiter_if.sv
// Requester-side and UART-side signal bundle for buff_uart_arbiter.
// master = the arbiter, slave = the clients/UART around it.
interface buff_uart_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_write;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]         rsp_data;
  logic [ADDR_WIDTH-1:0]    uart_active_address;
  logic                     uart_read_enable;
  logic                     uart_write_enable;
  logic [WIDTH-1:0]         uart_data_in;
  logic [WIDTH-1:0]         uart_data_out;
  logic                     tx_busy;

  modport master (
    input  req_valid, req_write, req_data, uart_data_out,
    output req_ready, rsp_valid, rsp_data, uart_active_address,
           uart_read_enable, uart_write_enable, uart_data_in, tx_busy
  );

  modport slave (
    output req_valid, req_write, req_data, uart_data_out,
    input  req_ready, rsp_valid, rsp_data, uart_active_address,
           uart_read_enable, uart_write_enable, uart_data_in, tx_busy
  );
endinterface

// File: rtl/buff_uart_arbiter.sv
// Round-robin sharing of one buff_uart port between NUM_REQ requesters.
// Sequences TX push / RX pop strobes, paces TX by a frame guard, routes RX data back.
module buff_uart_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned RX_ADDRESS = 3,
  parameter int unsigned TX_ADDRESS = 4,
  parameter int unsigned CLOCK_FREQ = 50000000,
  parameter int unsigned BAUD_RATE  = 115200
) (
  input logic                clock,
  input logic                reset,
  buff_uart_arbiter_if.master bus
);
  localparam int unsigned TICKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned FRAME_TICKS   = (WIDTH + 2) * TICKS_PER_BIT + 2;
  localparam int unsigned GUARD_W       = $clog2(FRAME_TICKS + 1);
  localparam int unsigned IDX_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE_TX, S_ISSUE_RX, S_RX_CAPTURE} state_e;

  state_e               state_q, state_n;
  logic [IDX_W-1:0]     ptr_q, ptr_n, grant_q, grant_n;
  logic [WIDTH-1:0]     tx_byte_q, tx_byte_n;
  logic [GUARD_W-1:0]   guard_q, guard_n;
  logic                 cap_q, cap_n;

  logic [NUM_REQ-1:0]    req_ready_q, req_ready_n, rsp_valid_q, rsp_valid_n;
  logic [WIDTH-1:0]      rsp_data_q, rsp_data_n, data_in_q, data_in_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n;
  logic                  rd_en_q, rd_en_n, wr_en_q, wr_en_n, tx_busy_q, tx_busy_n;

  logic [NUM_REQ-1:0]   eligible;
  logic                 found;
  logic [IDX_W-1:0]     sel, cidx;
  int unsigned          cand;
  logic [WIDTH-1:0]     req_bytes [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign req_bytes[g] = bus.req_data[g*WIDTH +: WIDTH];
  end

  // Round-robin search from ptr_q; a guarded TX is skipped so RX is never stalled.
  always_comb begin
    eligible = bus.req_valid & (~bus.req_write | {NUM_REQ{guard_q == '0}});
    found    = 1'b0;
    sel      = '0;
    cand     = 0;
    cidx     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cidx = IDX_W'(cand);
      if (!found && eligible[cidx]) begin
        found = 1'b1;
        sel   = cidx;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      tx_byte_q   <= '0;
      guard_q     <= '0;
      cap_q       <= 1'b0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      addr_q      <= '0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      data_in_q   <= '0;
      tx_busy_q   <= 1'b0;
    end else begin
      state_q     <= state_n;
      ptr_q       <= ptr_n;
      grant_q     <= grant_n;
      tx_byte_q   <= tx_byte_n;
      guard_q     <= guard_n;
      cap_q       <= cap_n;
      req_ready_q <= req_ready_n;
      rsp_valid_q <= rsp_valid_n;
      rsp_data_q  <= rsp_data_n;
      addr_q      <= addr_n;
      rd_en_q     <= rd_en_n;
      wr_en_q     <= wr_en_n;
      data_in_q   <= data_in_n;
      tx_busy_q   <= tx_busy_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    ptr_n       = ptr_q;
    grant_n     = grant_q;
    tx_byte_n   = tx_byte_q;
    guard_n     = (guard_q != '0) ? guard_q - GUARD_W'(1) : '0;
    cap_n       = 1'b0;
    req_ready_n = '0;
    rsp_valid_n = '0;
    rsp_data_n  = rsp_data_q;
    addr_n      = '0;
    rd_en_n     = 1'b0;
    wr_en_n     = 1'b0;
    data_in_n   = data_in_q;

    // UART data is valid the cycle after the RX_CAPTURE state; it overlaps the next arbitration.
    if (cap_q) begin
      rsp_valid_n[grant_q] = 1'b1;
      rsp_data_n           = bus.uart_data_out;
    end

    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_n          = sel;
          ptr_n            = (sel == IDX_W'(NUM_REQ - 1)) ? '0 : sel + IDX_W'(1);
          tx_byte_n        = req_bytes[sel];
          req_ready_n[sel] = 1'b1;
          state_n          = bus.req_write[sel] ? S_ISSUE_TX : S_ISSUE_RX;
        end
      end
      S_ISSUE_TX: begin
        addr_n    = ADDR_WIDTH'(TX_ADDRESS);
        rd_en_n   = 1'b1;
        data_in_n = tx_byte_q;
        guard_n   = GUARD_W'(FRAME_TICKS);
        state_n   = S_IDLE;
      end
      S_ISSUE_RX: begin
        addr_n  = ADDR_WIDTH'(RX_ADDRESS);
        wr_en_n = 1'b1;
        state_n = S_RX_CAPTURE;
      end
      S_RX_CAPTURE: begin
        cap_n   = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    tx_busy_n = (guard_n != '0);
  end

  assign bus.req_ready           = req_ready_q;
  assign bus.rsp_valid           = rsp_valid_q;
  assign bus.rsp_data            = rsp_data_q;
  assign bus.uart_active_address = addr_q;
  assign bus.uart_read_enable    = rd_en_q;
  assign bus.uart_write_enable   = wr_en_q;
  assign bus.uart_data_in        = data_in_q;
  assign bus.tx_busy             = tx_busy_q;
endmodule

// File: tb/tb_buff_uart_arbiter.sv
// Scoreboard bench for buff_uart_arbiter with a loopback UART model (TX pushes feed RX pops).
module tb_buff_uart_arbiter;
  localparam int unsigned NUM_REQ    = 4;
  localparam int unsigned WIDTH      = 8;
  localparam int unsigned ADDR_WIDTH = 8;
  localparam int unsigned FRAME      = 162;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } rsp_t;

  logic clock;
  logic reset;
  int   n_cmp, n_err, strobe_viol;

  logic [7:0] model_q [$];
  logic [7:0] exp_tx [$];
  rsp_t       exp_rsp [$];
  int         exp_grant [$];

  buff_uart_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  buff_uart_arbiter #(
    .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .RX_ADDRESS(3), .TX_ADDRESS(4),
    .CLOCK_FREQ(16), .BAUD_RATE(1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural UART: push on TX strobe, pop (next cycle) on RX strobe.
  always @(posedge clock) begin
    if (bus.uart_read_enable === 1'b1 && bus.uart_write_enable === 1'b1) strobe_viol++;
    if (bus.uart_read_enable === 1'b1) model_q.push_back(bus.uart_data_in);
    if (bus.uart_write_enable === 1'b1) begin
      if (model_q.size() > 0) bus.uart_data_out <= model_q.pop_front();
      else bus.uart_data_out <= 8'hEE;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic w, input logic [7:0] d);
    bus.req_valid[i]          = v;
    bus.req_write[i]          = w;
    bus.req_data[i*WIDTH +: WIDTH] = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [NUM_REQ*2+WIDTH-1:0]         hs;
    logic [ADDR_WIDTH+WIDTH+2:0]        ua;
    bus.req_valid = '0; bus.req_write = '0; bus.req_data = '0; bus.uart_data_out = '0;
    reset = 1'b1;
    tick(); tick();
    hs = {bus.req_ready, bus.rsp_valid, bus.rsp_data};
    ua = {bus.uart_active_address, bus.uart_read_enable, bus.uart_write_enable, bus.uart_data_in, bus.tx_busy};
    n_cmp++; if (hs !== '0) begin n_err++; $display("FAIL reset_handshake: got %h expected 0", hs); end
    n_cmp++; if (ua !== '0) begin n_err++; $display("FAIL reset_uart: got %h expected 0", ua); end
    reset = 1'b0;
    tick();
    n_cmp++; if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL idle_ready: got %b expected 0000", bus.req_ready); end
  endtask

  task automatic test_tx();
    int busy;
    model_q.delete();
    exp_tx.push_back(8'h0A);
    set_req(1, 1'b1, 1'b1, 8'h0A);
    tick();
    n_cmp++; if (bus.req_ready !== 4'b0010) begin n_err++; $display("FAIL tx_ready: got %b expected 0010", bus.req_ready); end
    set_req(1, 1'b0, 1'b0, 8'h00);
    tick();
    n_cmp++; if ({bus.uart_active_address, bus.uart_read_enable, bus.uart_write_enable} !== {8'd4, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL tx_strobe: got addr=%0d re=%b we=%b expected addr=4 re=1 we=0",
                        bus.uart_active_address, bus.uart_read_enable, bus.uart_write_enable);
    end
    n_cmp++; if (bus.uart_data_in !== exp_tx[0]) begin n_err++; $display("FAIL tx_data: got %h expected %h", bus.uart_data_in, exp_tx[0]); end
    void'(exp_tx.pop_front());
    busy = (bus.tx_busy === 1'b1) ? 1 : 0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (bus.tx_busy === 1'b1) busy++;
      else break;
    end
    n_cmp++; if (busy !== FRAME) begin n_err++; $display("FAIL tx_busy_len: got %0d expected %0d", busy, FRAME); end
    n_cmp++; if ({bus.uart_active_address, bus.uart_read_enable, bus.uart_data_in} !== {8'd0, 1'b0, 8'h0A}) begin
      n_err++; $display("FAIL tx_idle_bus: got addr=%0d re=%b data_in=%h expected 0 0 0a",
                        bus.uart_active_address, bus.uart_read_enable, bus.uart_data_in);
    end
  endtask

  task automatic test_rx();
    rsp_t r;
    model_q.delete();
    model_q.push_back(8'h3E);
    exp_rsp.push_back('{2, 8'h3E});
    set_req(2, 1'b1, 1'b0, 8'h00);
    tick();
    n_cmp++; if (bus.req_ready !== 4'b0100) begin n_err++; $display("FAIL rx_ready: got %b expected 0100", bus.req_ready); end
    set_req(2, 1'b0, 1'b0, 8'h00);
    tick();
    n_cmp++; if ({bus.uart_active_address, bus.uart_read_enable, bus.uart_write_enable} !== {8'd3, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL rx_strobe: got addr=%0d re=%b we=%b expected addr=3 re=0 we=1",
                        bus.uart_active_address, bus.uart_read_enable, bus.uart_write_enable);
    end
    tick();
    n_cmp++; if (bus.rsp_valid !== 4'b0000) begin n_err++; $display("FAIL rx_early: got %b expected 0000", bus.rsp_valid); end
    tick();
    r = exp_rsp.pop_front();
    n_cmp++; if (bus.rsp_valid !== (4'b0001 << r.idx)) begin n_err++; $display("FAIL rx_valid: got %b expected %b", bus.rsp_valid, 4'b0001 << r.idx); end
    n_cmp++; if (bus.rsp_data !== r.data) begin n_err++; $display("FAIL rx_data: got %h expected %h", bus.rsp_data, r.data); end
    tick();
    n_cmp++; if (bus.rsp_valid !== 4'b0000) begin n_err++; $display("FAIL rx_one_cycle: got %b expected 0000", bus.rsp_valid); end
  endtask

  task automatic test_fairness();
    int   last, granted, g;
    rsp_t r;
    logic [3:0] ev;
    do_reset();
    model_q.delete();
    for (int k = 0; k < 8; k++) begin
      model_q.push_back(8'(8'h10 + k));
      exp_grant.push_back(k % 4);
      exp_rsp.push_back('{k % 4, 8'(8'h10 + k)});
    end
    bus.req_write = '0;
    bus.req_valid = 4'hF;
    last = -1; granted = 0;
    for (int c = 0; c < 80 && (exp_grant.size() > 0 || exp_rsp.size() > 0); c++) begin
      tick();
      if (bus.req_ready !== 4'b0000) begin
        g  = (exp_grant.size() > 0) ? exp_grant.pop_front() : -1;
        ev = (g >= 0) ? 4'(4'b0001 << g) : 4'b0000;
        n_cmp++; if (bus.req_ready !== ev) begin n_err++; $display("FAIL fair_grant: got %b expected %b", bus.req_ready, ev); end
        if (last >= 0) begin
          n_cmp++; if (c - last !== 3) begin n_err++; $display("FAIL fair_spacing: got %0d expected 3", c - last); end
        end
        last = c;
        granted++;
        if (granted == 8) bus.req_valid = '0;
      end
      if (bus.rsp_valid !== 4'b0000) begin
        if (exp_rsp.size() > 0) r = exp_rsp.pop_front();
        else r = '{-1, 8'h00};
        ev = (r.idx >= 0) ? 4'(4'b0001 << r.idx) : 4'b0000;
        n_cmp++; if ({bus.rsp_valid, bus.rsp_data} !== {ev, r.data}) begin
          n_err++; $display("FAIL fair_rsp: got %b/%h expected %b/%h", bus.rsp_valid, bus.rsp_data, ev, r.data);
        end
      end
    end
    n_cmp++; if (exp_grant.size() + exp_rsp.size() !== 0) begin
      n_err++; $display("FAIL fair_timeout: got %0d outstanding expected 0", exp_grant.size() + exp_rsp.size());
    end
    exp_grant.delete(); exp_rsp.delete();
  endtask

  task automatic test_pacing();
    int tx1, tx2, rxr, fall;
    bit seen_busy;
    rsp_t r;
    model_q.delete();
    exp_tx.push_back(8'h01); exp_tx.push_back(8'h02);
    exp_rsp.push_back('{1, 8'h01});
    set_req(0, 1'b1, 1'b1, 8'h01);
    set_req(1, 1'b1, 1'b0, 8'h00);
    tx1 = -1; tx2 = -1; rxr = -1; fall = -1; seen_busy = 0;
    for (int c = 0; c < 400 && !(tx2 >= 0 && exp_tx.size() == 0 && exp_rsp.size() == 0); c++) begin
      tick();
      if (bus.tx_busy === 1'b1) seen_busy = 1;
      else if (seen_busy && fall < 0) fall = c;
      if (bus.req_ready[0] === 1'b1) begin
        if (tx1 < 0) begin tx1 = c; set_req(0, 1'b1, 1'b1, 8'h02); end
        else begin tx2 = c; set_req(0, 1'b0, 1'b0, 8'h00); end
      end
      if (bus.req_ready[1] === 1'b1) begin rxr = c; set_req(1, 1'b0, 1'b0, 8'h00); end
      if (bus.uart_read_enable === 1'b1) begin
        n_cmp++;
        if (exp_tx.size() == 0) begin n_err++; $display("FAIL pace_extra_tx: got %h expected none", bus.uart_data_in); end
        else if (bus.uart_data_in !== exp_tx[0]) begin n_err++; $display("FAIL pace_tx_data: got %h expected %h", bus.uart_data_in, exp_tx[0]); end
        if (exp_tx.size() > 0) void'(exp_tx.pop_front());
      end
      if (bus.rsp_valid !== 4'b0000) begin
        if (exp_rsp.size() > 0) r = exp_rsp.pop_front();
        else r = '{-1, 8'h00};
        n_cmp++; if ({bus.rsp_valid, bus.rsp_data} !== {((r.idx >= 0) ? 4'(4'b0001 << r.idx) : 4'b0000), r.data}) begin
          n_err++; $display("FAIL pace_rsp: got %b/%h expected idx %0d data %h", bus.rsp_valid, bus.rsp_data, r.idx, r.data);
        end
      end
    end
    n_cmp++; if (rxr !== tx1 + 2) begin n_err++; $display("FAIL pace_rx_in_guard: got cycle %0d expected %0d", rxr, tx1 + 2); end
    n_cmp++; if (!(rxr >= 0 && fall > rxr)) begin n_err++; $display("FAIL pace_rx_before_fall: got rx %0d fall %0d expected rx before fall", rxr, fall); end
    n_cmp++; if (tx2 !== fall + 1 || fall < 0) begin n_err++; $display("FAIL pace_tx2: got cycle %0d expected %0d", tx2, fall + 1); end
    n_cmp++; if (fall - tx1 !== FRAME + 1) begin n_err++; $display("FAIL pace_guard: got %0d expected %0d", fall - tx1, FRAME + 1); end
    exp_tx.delete(); exp_rsp.delete();
  endtask

  task automatic test_reset_mid();
    int   early;
    rsp_t r;
    logic [NUM_REQ*2+WIDTH+ADDR_WIDTH+WIDTH+2:0] all_out;
    for (int c = 0; c < 300 && bus.tx_busy === 1'b1; c++) tick();
    n_cmp++; if (bus.tx_busy !== 1'b0) begin n_err++; $display("FAIL mid_drain: got %b expected 0", bus.tx_busy); end
    set_req(2, 1'b1, 1'b0, 8'h00);
    tick();
    n_cmp++; if (bus.req_ready !== 4'b0100) begin n_err++; $display("FAIL mid_ready: got %b expected 0100", bus.req_ready); end
    reset = 1'b1;
    bus.req_write = '0;
    bus.req_valid = 4'b1010;
    model_q.delete();
    model_q.push_back(8'h55);
    exp_rsp.push_back('{1, 8'h55});
    tick();
    all_out = {bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.uart_active_address, bus.uart_data_in,
               bus.uart_read_enable, bus.uart_write_enable, bus.tx_busy};
    n_cmp++; if (all_out !== '0) begin n_err++; $display("FAIL mid_reset_out: got %h expected 0", all_out); end
    reset = 1'b0;
    early = (bus.rsp_valid !== 4'b0000) ? 1 : 0;
    tick();
    n_cmp++; if (bus.req_ready !== 4'b0010) begin n_err++; $display("FAIL mid_lowest: got %b expected 0010", bus.req_ready); end
    bus.req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      if (bus.rsp_valid !== 4'b0000) early++;
      tick();
    end
    n_cmp++; if (early !== 0) begin n_err++; $display("FAIL mid_dropped_rsp: got %0d pulses expected 0", early); end
    r = exp_rsp.pop_front();
    n_cmp++; if ({bus.rsp_valid, bus.rsp_data} !== {4'(4'b0001 << r.idx), r.data}) begin
      n_err++; $display("FAIL mid_new_rsp: got %b/%h expected %b/%h", bus.rsp_valid, bus.rsp_data, 4'(4'b0001 << r.idx), r.data);
    end
  endtask

  task automatic test_loopback();
    bit   seen, got;
    rsp_t r;
    model_q.delete();
    exp_rsp.push_back('{0, 8'h0A});
    set_req(0, 1'b1, 1'b1, 8'h0A);
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin tick(); got = (bus.req_ready[0] === 1'b1); end
    n_cmp++; if (!got) begin n_err++; $display("FAIL loop_tx_ready: got none expected req_ready[0]"); end
    set_req(0, 1'b0, 1'b0, 8'h00);
    seen = 0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (bus.tx_busy === 1'b1) seen = 1;
      else if (seen) break;
    end
    n_cmp++; if (!(seen && bus.tx_busy === 1'b0)) begin n_err++; $display("FAIL loop_guard: got busy=%b seen=%0d expected 0/1", bus.tx_busy, seen); end
    set_req(0, 1'b1, 1'b0, 8'h00);
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin tick(); got = (bus.req_ready[0] === 1'b1); end
    set_req(0, 1'b0, 1'b0, 8'h00);
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin tick(); got = (bus.rsp_valid !== 4'b0000); end
    r = exp_rsp.pop_front();
    n_cmp++; if ({bus.rsp_valid, bus.rsp_data} !== {4'(4'b0001 << r.idx), r.data}) begin
      n_err++; $display("FAIL loop_rsp: got %b/%h expected %b/%h", bus.rsp_valid, bus.rsp_data, 4'(4'b0001 << r.idx), r.data);
    end
    n_cmp++; if (strobe_viol !== 0) begin n_err++; $display("FAIL both_strobes: got %0d cycles expected 0", strobe_viol); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; strobe_viol = 0;
    reset = 1'b1;
    test_reset();
    test_tx();
    test_rx();
    test_fairness();
    test_pacing();
    test_reset_mid();
    test_loopback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
